pc_sequencer: RTL and testbench

- Program-counter stage that sits directly upstream of the 7-bit carry-look-ahead adder.
- Drives the adder's A/B/cin operands and registers the adder result R as the next PC.
- Issues each PC to instruction fetch over a valid/ready handshake.
- Accepts one next-PC command per issued PC from decode: increment, conditional relative branch, absolute jump or hold.

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_ret_stack.sv | 66 ++++++
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: PC width,
// next-PC command encodings and FSM state encodings.
package pc_seq_pkg;

  // Fixed to the width of the downstream carry-look-ahead adder.
  localparam int unsigned PC_W = 7;
  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_INC        = 3'b000,
    OP_BRANCH_REL = 3'b001,
    OP_JUMP_ABS   = 3'b010,
    OP_HOLD       = 3'b011,
    OP_CALL       = 3'b100,
    OP_RET        = 3'b101
  } cmd_op_e;

  typedef enum logic {
    S_ISSUE    = 1'b0,
    S_WAIT_CMD = 1'b1
  } state_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty leaves the stack unchanged.
// Ports:
//   clk, reset            clock, async active-high reset
//   push_i, push_data_i   push a return address
//   pop_i, pop_data_o     pop; pop_data_o always shows the top entry
//   full_o, empty_o       occupancy flags
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] pop_data_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  // Top entry sits one slot behind the write pointer, modulo DEPTH.
  assign top_ptr    = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;
  assign pop_data_o = mem_q[top_ptr];

  // Pointer / occupancy update; count saturates so overwrite keeps it full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (!full_o) count_d = count_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding an external 7-bit adder. Issues each PC to
// fetch (valid/ready), then accepts one next-PC command from decode.
// Optional macro CALL_STACK_EN adds CALL/RET with a return stack and the
// sticky stack_err output; without it CALL/RET behave as INC.
// Ports:
//   clk, reset                 clock, async active-high reset
//   pc, pc_valid, pc_ready     PC issue handshake to fetch
//   cmd_valid, cmd_ready       command handshake from decode
//   cmd_op, cmd_operand, cond  next-PC command
//   adder_a/b/cin, adder_r     operands to / result from the adder
//   stack_err                  sticky over/underflow (CALL_STACK_EN only)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 7'd0
`ifdef CALL_STACK_EN
  , parameter int unsigned STACK_DEPTH = 4
`endif
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [PC_W-1:0] cmd_operand,
  input  logic            cond,
  output logic [PC_W-1:0] adder_a,
  output logic [PC_W-1:0] adder_b,
  output logic            adder_cin,
  input  logic [PC_W-1:0] adder_r
`ifdef CALL_STACK_EN
  , output logic          stack_err
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_sel;
  logic            accept;

  assign accept = (state_q == S_WAIT_CMD) && cmd_valid;
  assign pc     = pc_q;

`ifdef CALL_STACK_EN
  logic            push, pop, stk_full, stk_empty, stack_err_q;
  logic [PC_W-1:0] pop_data;

  assign push      = accept && (cmd_op == OP_CALL);
  assign pop       = accept && (cmd_op == OP_RET);
  assign stack_err = stack_err_q;

  pc_ret_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (pop),
    .push_data_i(adder_r),
    .pop_data_o (pop_data),
    .full_o     (stk_full),
    .empty_o    (stk_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stack_err_q <= 1'b0;
    else if ((push && stk_full) || (pop && stk_empty)) stack_err_q <= 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_ISSUE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ISSUE:    if (pc_ready)  state_d = S_WAIT_CMD;
      S_WAIT_CMD: if (cmd_valid) state_d = S_ISSUE;
      default:                   state_d = S_ISSUE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    pc_valid  = 1'b0;
    cmd_ready = 1'b0;
    case (state_q)
      S_ISSUE:    pc_valid  = 1'b1;
      S_WAIT_CMD: cmd_ready = 1'b1;
      default:    pc_valid  = 1'b1;
    endcase
  end

  // Adder operands: pc+1 unless a taken relative branch is being accepted.
  always_comb begin
    adder_a   = pc_q;
    adder_b   = '0;
    adder_cin = 1'b1;
    if (accept && (cmd_op == OP_BRANCH_REL) && cond) begin
      adder_b   = cmd_operand;
      adder_cin = 1'b0;
    end
  end

  // Next-PC select; adder_r already holds pc+1 or pc+offset as required.
  always_comb begin
    pc_sel = adder_r;
    case (cmd_op)
      OP_JUMP_ABS: pc_sel = cmd_operand;
      OP_HOLD:     pc_sel = pc_q;
`ifdef CALL_STACK_EN
      OP_CALL:     pc_sel = cmd_operand;
      OP_RET:      pc_sel = stk_empty ? adder_r : pop_data;
`endif
      default:     pc_sel = adder_r;
    endcase
    pc_d = accept ? pc_sel : pc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected PCs are queued when a command
// is driven and compared when the sequencer reissues. Models the external
// adder combinationally. Build with +define+CALL_STACK_EN for stack tests.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [PC_W-1:0] pc;
  logic            pc_valid, pc_ready;
  logic            cmd_valid, cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic [PC_W-1:0] cmd_operand;
  logic            cond;
  logic [PC_W-1:0] adder_a, adder_b, adder_r;
  logic            adder_cin;
`ifdef CALL_STACK_EN
  logic            stack_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [PC_W-1:0] sb_q[$];
  logic [PC_W-1:0] model_pc;
`ifdef CALL_STACK_EN
  logic [PC_W-1:0] model_stk[$];
  logic            model_err;
`endif

  always #5 clk = ~clk;

  // External 7-bit adder, no carry-out.
  assign adder_r = adder_a + adder_b + {6'b0, adder_cin};

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_operand(cmd_operand),
    .cond       (cond),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_r    (adder_r)
`ifdef CALL_STACK_EN
    , .stack_err(stack_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference next-PC model, independent of the DUT's adder wiring.
  task automatic model_next(input logic [OP_W-1:0] op, input logic [PC_W-1:0] opnd,
                            input logic c);
    logic [PC_W-1:0] inc;
    inc = model_pc + 7'd1;
    case (op)
      3'b001:  model_pc = c ? model_pc + opnd : inc;
      3'b010:  model_pc = opnd;
      3'b011:  model_pc = model_pc;
`ifdef CALL_STACK_EN
      3'b100: begin
        if (model_stk.size() == 4) begin
          void'(model_stk.pop_front());
          model_err = 1'b1;
        end
        model_stk.push_back(inc);
        model_pc = opnd;
      end
      3'b101: begin
        if (model_stk.size() == 0) begin
          model_pc  = inc;
          model_err = 1'b1;
        end else begin
          model_pc = model_stk.pop_back();
        end
      end
`endif
      default: model_pc = inc;
    endcase
  endtask

  // At a negedge in ISSUE: compare pc with the scoreboard, then hand it off.
  task automatic issue();
    logic [PC_W-1:0] exp;
    check_eq("pc_valid_issue", 32'(pc_valid), 32'd1);
    check_eq("cmd_ready_issue", 32'(cmd_ready), 32'd0);
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
      exp = pc;
    end else begin
      exp = sb_q.pop_front();
    end
    check_eq("pc", 32'(pc), 32'(exp));
`ifdef CALL_STACK_EN
    check_eq("stack_err", 32'(stack_err), 32'(model_err));
`endif
    pc_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pc_ready = 1'b0;
    check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    check_eq("pc_valid_wait", 32'(pc_valid), 32'd0);
  endtask

  // At a negedge in WAIT_CMD: drive one command, queue the expected PC.
  task automatic send_cmd(input logic [OP_W-1:0] op, input logic [PC_W-1:0] opnd,
                          input logic c);
    logic br_taken;
    logic [PC_W-1:0] cur;
    cur      = model_pc;
    br_taken = (op == 3'b001) && c;
    model_next(op, opnd, c);
    sb_q.push_back(model_pc);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = opnd;
    cond        = c;
    #1;
    check_eq("adder_a", 32'(adder_a), 32'(cur));
    check_eq("adder_b", 32'(adder_b), br_taken ? 32'(opnd) : 32'd0);
    check_eq("adder_cin", 32'(adder_cin), br_taken ? 32'd0 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic step(input logic [OP_W-1:0] op, input logic [PC_W-1:0] opnd, input logic c);
    send_cmd(op, opnd, c);
    issue();
  endtask

  task automatic model_reset();
    sb_q.delete();
    model_pc = 7'd0;
`ifdef CALL_STACK_EN
    model_stk.delete();
    model_err = 1'b0;
`endif
    sb_q.push_back(model_pc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    issue();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    pc_ready    = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_operand = '0;
    cond        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_pc_valid", 32'(pc_valid), 32'd1);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_adder_a", 32'(adder_a), 32'd0);
    check_eq("rst_adder_b", 32'(adder_b), 32'd0);
    check_eq("rst_adder_cin", 32'(adder_cin), 32'd1);
    reset = 1'b0;
    model_reset();
    issue();

    for (int i = 0; i < 4; i++) step(3'b000, 7'd0, 1'b0);   // 1,2,3,4
    step(3'b010, 7'd127, 1'b0);
    step(3'b000, 7'd0, 1'b0);                               // wrap to 0
    step(3'b010, 7'd2, 1'b0);
    step(3'b001, 7'h7C, 1'b1);                              // 126
    step(3'b010, 7'd10, 1'b0);
    step(3'b001, 7'd5, 1'b0);                               // 11
    step(3'b010, 7'd10, 1'b0);
    step(3'b001, 7'd5, 1'b1);                               // 15
    step(3'b010, 7'h40, 1'b0);                              // 64
    step(3'b110, 7'd9, 1'b1);                               // reserved -> 65
    step(3'b111, 7'd9, 1'b0);                               // reserved -> 66

    // Stall in ISSUE with a stray command that must be ignored.
    send_cmd(3'b000, 7'd0, 1'b0);
    cmd_valid   = 1'b1;
    cmd_op      = 3'b010;
    cmd_operand = 7'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_pc", 32'(pc), 32'(model_pc));
      check_eq("stall_pc_valid", 32'(pc_valid), 32'd1);
      check_eq("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    issue();
    step(3'b011, 7'd5, 1'b1);                               // HOLD reissues

    // Async reset mid-WAIT_CMD with a pending jump.
    cmd_valid   = 1'b1;
    cmd_op      = 3'b010;
    cmd_operand = 7'h55;
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_pc", 32'(pc), 32'd0);
    check_eq("async_rst_pc_valid", 32'(pc_valid), 32'd1);
    check_eq("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_dropped", 32'(pc), 32'd0);
    cmd_valid = 1'b0;
    reset     = 1'b0;
    model_reset();
    issue();
    step(3'b000, 7'd0, 1'b0);

`ifdef CALL_STACK_EN
    step(3'b010, 7'd20, 1'b0);
    step(3'b100, 7'd50, 1'b0);                              // CALL -> 50
    step(3'b101, 7'd0, 1'b0);                               // RET -> 21
    step(3'b010, 7'd9, 1'b0);
    step(3'b101, 7'd0, 1'b0);                               // empty RET -> 10, err
    do_reset();
    for (int i = 0; i < 5; i++) step(3'b100, 7'(30 + 10 * i), 1'b0);
    for (int i = 0; i < 5; i++) step(3'b101, 7'd0, 1'b0);   // 4 pops then empty
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
